// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - UART command byte decoder driving register strobes and TX responses
module uart_cmd_decoder #(
  parameter int ADDR_W      = 3,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_fifo_e,
  output logic              o_rx_rd,
  input  logic              i_tx_fifo_f,
  output logic              o_tx_wr,
  output logic [7:0]        o_tx_data,
  output logic [ADDR_W-1:0] o_rwaddr,
  output logic [7:0]        o_write_data,
  output logic              o_wr_req,
  output logic              o_rd_req,
  input  logic [7:0]        i_read_data,
  output logic              o_err,
  output logic [1:0]        o_err_code
);

  // Counter must hold TIMEOUT_CYC-1; guard the degenerate single-cycle case.
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  // Bits [6:ADDR_W] of a command byte are reserved; the all-ones offset is invalid.
  localparam logic [7:0]        OFF_MASK = 8'((1 << ADDR_W) - 1);
  localparam logic [6:0]        RSV_MASK = ~OFF_MASK[6:0];
  localparam logic [ADDR_W-1:0] OFF_BAD  = '1;

  localparam logic [1:0] ERR_ADDR    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD_CAP,
    S_DAT_WAIT,
    S_DAT_CAP,
    S_WR,
    S_RD_REQ,
    S_RD_CAP,
    S_TX_PUSH,
    S_ERR
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [6:0]        r_cmd;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_rwaddr;
  logic [7:0]        r_write_data;
  logic [7:0]        r_tx_data;
  logic [1:0]        r_err_code;

  logic       w_rx_rd;
  logic       w_wr_req;
  logic       w_rd_req;
  logic       w_tx_wr;
  logic       w_err;
  logic [1:0] w_err_code_nxt;
  logic       w_rx_bad;
  logic       w_cmd_bad;
  logic       w_commit_rd;
  logic       w_commit_wr;

  function automatic logic f_addr_bad(input logic [6:0] b);
    return ((b & RSV_MASK) != 7'd0) || (b[ADDR_W-1:0] == OFF_BAD);
  endfunction

  // In CMD_CAP the command is still on i_rx_data; in DAT_CAP it sits in r_cmd.
  assign w_rx_bad    = f_addr_bad(i_rx_data[6:0]);
  assign w_cmd_bad   = f_addr_bad(r_cmd);
  assign w_commit_rd = (r_state == S_CMD_CAP) && !i_rx_data[7] && !w_rx_bad;
  assign w_commit_wr = (r_state == S_DAT_CAP) && !w_cmd_bad;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and single-cycle strobes.
  always_comb begin
    w_state_nxt    = r_state;
    w_rx_rd        = 1'b0;
    w_wr_req       = 1'b0;
    w_rd_req       = 1'b0;
    w_tx_wr        = 1'b0;
    w_err          = 1'b0;
    w_err_code_nxt = r_err_code;
    case (r_state)
      S_IDLE: begin
        if (!i_rx_fifo_e) begin
          w_rx_rd     = 1'b1;
          w_state_nxt = S_CMD_CAP;
        end
      end
      S_CMD_CAP: begin
        if (i_rx_data[7]) begin
          w_state_nxt = S_DAT_WAIT;
        end else if (w_rx_bad) begin
          w_state_nxt    = S_ERR;
          w_err_code_nxt = ERR_ADDR;
        end else begin
          w_state_nxt = S_RD_REQ;
        end
      end
      S_DAT_WAIT: begin
        if (!i_rx_fifo_e) begin
          w_rx_rd     = 1'b1;
          w_state_nxt = S_DAT_CAP;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt    = S_ERR;
          w_err_code_nxt = ERR_TIMEOUT;
        end
      end
      S_DAT_CAP: begin
        // A write to a bad address still consumes its data byte.
        if (w_cmd_bad) begin
          w_state_nxt    = S_ERR;
          w_err_code_nxt = ERR_ADDR;
        end else begin
          w_state_nxt = S_WR;
        end
      end
      S_WR: begin
        w_wr_req    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_RD_REQ: begin
        w_rd_req    = 1'b1;
        w_state_nxt = S_RD_CAP;
      end
      S_RD_CAP: begin
        w_state_nxt = S_TX_PUSH;
      end
      S_TX_PUSH: begin
        if (!i_tx_fifo_f) begin
          w_tx_wr     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_ERR: begin
        w_err       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Hold the command byte while waiting for its write data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd <= 7'd0;
    end else if (r_state == S_CMD_CAP) begin
      r_cmd <= i_rx_data[6:0];
    end
  end

  // Inter-byte timeout counter: zero outside DAT_WAIT, saturating inside it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (r_state != S_DAT_WAIT) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Register address only changes when a valid transaction commits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rwaddr <= '0;
    end else if (w_commit_rd) begin
      r_rwaddr <= i_rx_data[ADDR_W-1:0];
    end else if (w_commit_wr) begin
      r_rwaddr <= r_cmd[ADDR_W-1:0];
    end
  end

  // Write data is latched with the address so both are stable under o_wr_req.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_write_data <= 8'd0;
    end else if (w_commit_wr) begin
      r_write_data <= i_rx_data;
    end
  end

  // Capture register read data the cycle after the read strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_data <= 8'd0;
    end else if (r_state == S_RD_CAP) begin
      r_tx_data <= i_read_data;
    end
  end

  // Error code is loaded on entry to ERR so it is valid alongside o_err.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_code <= 2'b00;
    end else begin
      r_err_code <= w_err_code_nxt;
    end
  end

  // IDLE pops combinationally, so gate the pop with reset to keep it low while held.
  assign o_rx_rd      = w_rx_rd & i_rst_n;
  assign o_wr_req     = w_wr_req;
  assign o_rd_req     = w_rd_req;
  assign o_tx_wr      = w_tx_wr;
  assign o_err        = w_err;
  assign o_err_code   = r_err_code;
  assign o_rwaddr     = r_rwaddr;
  assign o_write_data = r_write_data;
  assign o_tx_data    = r_tx_data;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - randomized bench for uart_cmd_decoder with transaction-level model
module tb_uart_cmd_decoder;

  localparam int ADDR_W = 3;
  localparam int T      = 40;
  localparam int K_WR   = 0;
  localparam int K_RD   = 1;
  localparam int K_ERR  = 2;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic [7:0]        i_rx_data = 8'd0;
  logic              i_rx_fifo_e = 1'b1;
  logic              o_rx_rd;
  logic              i_tx_fifo_f = 1'b0;
  logic              o_tx_wr;
  logic [7:0]        o_tx_data;
  logic [ADDR_W-1:0] o_rwaddr;
  logic [7:0]        o_write_data;
  logic              o_wr_req;
  logic              o_rd_req;
  logic [7:0]        i_read_data = 8'd0;
  logic              o_err;
  logic [1:0]        o_err_code;

  uart_cmd_decoder #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(T)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rx_data    (i_rx_data),
    .i_rx_fifo_e  (i_rx_fifo_e),
    .o_rx_rd      (o_rx_rd),
    .i_tx_fifo_f  (i_tx_fifo_f),
    .o_tx_wr      (o_tx_wr),
    .o_tx_data    (o_tx_data),
    .o_rwaddr     (o_rwaddr),
    .o_write_data (o_write_data),
    .o_wr_req     (o_wr_req),
    .o_rd_req     (o_rd_req),
    .i_read_data  (i_read_data),
    .o_err        (o_err),
    .o_err_code   (o_err_code)
  );

  initial forever #5 i_clk = ~i_clk;

  typedef struct {
    int         kind;
    logic [2:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t        expq[$];
  logic [7:0] rxq[$];
  logic [7:0] model_mem [0:7];
  logic [7:0] slave_mem [0:7];
  bit         pend = 1'b0;
  logic [7:0] pend_cmd = 8'd0;
  bit         force_full = 1'b0;
  bit         rand_full = 1'b0;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_pop = 0, n_wr = 0, n_rd = 0, n_tx = 0, n_err = 0;
  int last_pop_cyc = 0, last_tx_cyc = 0, last_err_lat = 0;
  logic [2:0] last_wr_addr = 3'd0, last_rd_addr = 3'd0;
  logic [7:0] last_wr_data = 8'd0, last_tx_data = 8'd0;
  logic [1:0] last_err_code = 2'd0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Command grammar: bit7 write, reserved bits [6:3] zero, offset 7 illegal.
  function automatic bit is_bad(input logic [7:0] b);
    return (b[6:3] != 4'd0) || (b[2:0] == 3'd7);
  endfunction

  function automatic void push_ev(input int kind, input logic [2:0] addr, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    expq.push_back(e);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (pend) begin
      pend = 1'b0;
      if (is_bad(pend_cmd)) push_ev(K_ERR, 3'd0, 8'h01);
      else begin
        model_mem[pend_cmd[2:0]] = b;
        push_ev(K_WR, pend_cmd[2:0], b);
      end
    end else if (b[7]) begin
      pend = 1'b1;
      pend_cmd = b;
    end else if (is_bad(b)) begin
      push_ev(K_ERR, 3'd0, 8'h01);
    end else begin
      push_ev(K_RD, b[2:0], model_mem[b[2:0]]);
    end
  endfunction

  task automatic send(input logic [7:0] b);
    rxq.push_back(b);
    model_byte(b);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #2;
    end
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((expq.size() != 0 || rxq.size() != 0) && n < limit) begin
      @(posedge i_clk);
      n++;
    end
    chk(n < limit, "drain_timeout", 32'(expq.size()), 32'd0);
    tick(3);
  endtask

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  // Environment: RX FIFO (data one cycle after pop), TX full, register block.
  initial begin
    bit pop, rdq;
    logic [2:0] ra;
    forever begin
      @(negedge i_clk);
      pop = o_rx_rd;
      rdq = o_rd_req;
      ra  = o_rwaddr;
      if (o_wr_req) slave_mem[o_rwaddr] = o_write_data;
      @(posedge i_clk);
      #1;
      if (pop && rxq.size() > 0) i_rx_data = rxq.pop_front();
      i_rx_fifo_e = (rxq.size() == 0);
      i_tx_fifo_f = rand_full ? ($urandom_range(0, 3) == 0) : force_full;
      i_read_data = rdq ? slave_mem[ra] : 8'($urandom);
    end
  end

  // Compare process: protocol invariants plus event order against the model.
  initial begin
    bit prev_rx, inflight, full_since_pop;
    ev_t e;
    prev_rx = 1'b0;
    inflight = 1'b0;
    full_since_pop = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        chk({o_rx_rd, o_tx_wr, o_tx_data, o_rwaddr, o_write_data, o_wr_req, o_rd_req, o_err, o_err_code} == 26'd0,
            "reset_outputs_zero",
            32'({o_rx_rd, o_tx_wr, o_tx_data, o_rwaddr, o_write_data, o_wr_req, o_rd_req, o_err, o_err_code}), 32'd0);
        prev_rx = 1'b0;
        inflight = 1'b0;
      end else begin
        chk(!(o_wr_req && o_rd_req), "wr_rd_exclusive", 32'({o_wr_req, o_rd_req}), 32'd0);
        if (o_rx_rd) begin
          chk(!i_rx_fifo_e, "pop_while_empty", 32'(i_rx_fifo_e), 32'd0);
          chk(!prev_rx, "pop_spacing", 32'(prev_rx), 32'd0);
          chk(!inflight, "pop_during_read", 32'(inflight), 32'd0);
          n_pop++;
          last_pop_cyc = cyc;
          full_since_pop = 1'b0;
        end
        if (i_tx_fifo_f) full_since_pop = 1'b1;
        if (o_wr_req) begin
          n_wr++;
          last_wr_addr = o_rwaddr;
          last_wr_data = o_write_data;
          chk(cyc - last_pop_cyc == 2, "wr_latency", 32'(cyc - last_pop_cyc), 32'd2);
          if (expq.size() == 0) chk(1'b0, "unexpected_wr", 32'(o_rwaddr), 32'd0);
          else begin
            e = expq.pop_front();
            chk(e.kind == K_WR, "wr_kind", 32'(e.kind), 32'(K_WR));
            chk(o_rwaddr == e.addr, "wr_addr", 32'(o_rwaddr), 32'(e.addr));
            chk(o_write_data == e.data, "wr_data", 32'(o_write_data), 32'(e.data));
          end
        end
        if (o_rd_req) begin
          n_rd++;
          last_rd_addr = o_rwaddr;
          inflight = 1'b1;
          if (expq.size() == 0) chk(1'b0, "unexpected_rd", 32'(o_rwaddr), 32'd0);
          else begin
            chk(expq[0].kind == K_RD, "rd_kind", 32'(expq[0].kind), 32'(K_RD));
            chk(o_rwaddr == expq[0].addr, "rd_addr", 32'(o_rwaddr), 32'(expq[0].addr));
          end
        end
        if (o_tx_wr) begin
          n_tx++;
          last_tx_data = o_tx_data;
          last_tx_cyc = cyc;
          inflight = 1'b0;
          chk(!i_tx_fifo_f, "tx_while_full", 32'(i_tx_fifo_f), 32'd0);
          if (!full_since_pop) chk(cyc - last_pop_cyc == 4, "rd_latency", 32'(cyc - last_pop_cyc), 32'd4);
          if (expq.size() == 0) chk(1'b0, "unexpected_tx", 32'(o_tx_data), 32'd0);
          else begin
            e = expq.pop_front();
            chk(e.kind == K_RD, "tx_kind", 32'(e.kind), 32'(K_RD));
            chk(o_tx_data == e.data, "tx_data", 32'(o_tx_data), 32'(e.data));
          end
        end
        if (o_err) begin
          n_err++;
          last_err_code = o_err_code;
          last_err_lat = cyc - last_pop_cyc;
          if (expq.size() == 0) chk(1'b0, "unexpected_err", 32'(o_err_code), 32'd0);
          else begin
            e = expq.pop_front();
            chk(e.kind == K_ERR, "err_kind", 32'(e.kind), 32'(K_ERR));
            chk(o_err_code == e.data[1:0], "err_code", 32'(o_err_code), 32'(e.data[1:0]));
          end
        end
        prev_rx = o_rx_rd;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got time %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, c_rel;
    logic [7:0] b, exp_rd;
    for (int i = 0; i < 8; i++) begin
      model_mem[i] = 8'($urandom);
      slave_mem[i] = model_mem[i];
    end
    model_mem[1] = 8'hA5;
    slave_mem[1] = 8'hA5;

    tick(3);
    i_rst_n = 1'b1;
    tick(2);

    // Write 0x80,0x05.
    n0 = n_tx;
    send(8'h80);
    send(8'h05);
    drain(200);
    chk(last_wr_addr == 3'd0, "lit_wr_addr", 32'(last_wr_addr), 32'd0);
    chk(last_wr_data == 8'h05, "lit_wr_data", 32'(last_wr_data), 32'h05);
    chk(n_tx == n0, "lit_wr_no_tx", 32'(n_tx), 32'(n0));

    // Read 0x01 returns 0xA5, pop to push in 4 cycles.
    send(8'h01);
    drain(200);
    chk(last_rd_addr == 3'd1, "lit_rd_addr", 32'(last_rd_addr), 32'd1);
    chk(last_tx_data == 8'hA5, "lit_rd_data", 32'(last_tx_data), 32'hA5);
    chk(last_tx_cyc - last_pop_cyc == 4, "lit_rd_latency", 32'(last_tx_cyc - last_pop_cyc), 32'd4);

    // Bad read address.
    n0 = n_wr + n_rd + n_tx;
    send(8'h07);
    drain(200);
    chk(last_err_code == 2'b01, "lit_bad_rd_code", 32'(last_err_code), 32'd1);
    chk(o_err_code == 2'b01, "lit_err_code_held", 32'(o_err_code), 32'd1);
    chk(n_wr + n_rd + n_tx == n0, "lit_bad_rd_no_strobe", 32'(n_wr + n_rd + n_tx), 32'(n0));

    // Bad write address: both bytes consumed.
    n0 = n_pop;
    n1 = n_wr;
    send(8'h87);
    send(8'h33);
    drain(200);
    chk(n_pop - n0 == 2, "lit_bad_wr_pops", 32'(n_pop - n0), 32'd2);
    chk(last_err_code == 2'b01, "lit_bad_wr_code", 32'(last_err_code), 32'd1);
    chk(n_wr == n1, "lit_bad_wr_no_wr", 32'(n_wr), 32'(n1));

    // Data byte on the last DAT_WAIT cycle is still accepted.
    n0 = n_err;
    send(8'h84);
    tick(T + 1);
    send(8'h3C);
    drain(400);
    chk(n_err == n0, "lit_edge_no_timeout", 32'(n_err), 32'(n0));
    chk(last_wr_addr == 3'd4, "lit_edge_wr_addr", 32'(last_wr_addr), 32'd4);
    chk(last_wr_data == 8'h3C, "lit_edge_wr_data", 32'(last_wr_data), 32'h3C);

    // One cycle later: timeout, and the late byte is a command.
    send(8'h82);
    pend = 1'b0;
    push_ev(K_ERR, 3'd0, 8'h02);
    tick(T + 2);
    send(8'h05);
    drain(400);
    chk(last_err_code == 2'b10, "lit_timeout_code", 32'(last_err_code), 32'd2);
    chk(last_err_lat == T + 2, "lit_timeout_latency", 32'(last_err_lat), 32'(T + 2));
    chk(last_rd_addr == 3'd5, "lit_late_byte_read", 32'(last_rd_addr), 32'd5);

    // TX backpressure for 20 cycles.
    force_full = 1'b1;
    tick(1);
    n0 = n_tx;
    exp_rd = model_mem[2];
    send(8'h02);
    tick(3);
    send(8'h81);
    send(8'h11);
    tick(17);
    chk(n_tx == n0, "lit_tx_held", 32'(n_tx), 32'(n0));
    chk(rxq.size() == 2, "lit_rx_queued", 32'(rxq.size()), 32'd2);
    force_full = 1'b0;
    c_rel = cyc;
    drain(200);
    chk(last_tx_cyc == c_rel + 1, "lit_tx_release", 32'(last_tx_cyc), 32'(c_rel + 1));
    chk(last_tx_data == exp_rd, "lit_tx_data", 32'(last_tx_data), 32'(exp_rd));

    // Reset while waiting for write data.
    n0 = n_wr;
    n1 = n_err;
    send(8'h83);
    tick(5);
    i_rst_n = 1'b0;
    pend = 1'b0;
    send(8'h04);
    tick(1);
    @(negedge i_clk);
    chk(o_rx_rd == 1'b0, "lit_reset_no_pop", 32'(o_rx_rd), 32'd0);
    chk(o_err_code == 2'b00, "lit_reset_err_code", 32'(o_err_code), 32'd0);
    tick(2);
    i_rst_n = 1'b1;
    drain(200);
    chk(n_wr == n0, "lit_reset_no_wr", 32'(n_wr), 32'(n0));
    chk(n_err == n1, "lit_reset_no_err", 32'(n_err), 32'(n1));
    chk(last_rd_addr == 3'd4, "lit_reset_next_cmd", 32'(last_rd_addr), 32'd4);
    chk(last_tx_data == 8'h3C, "lit_reset_read_back", 32'(last_tx_data), 32'h3C);

    // Randomized traffic with random TX backpressure.
    rand_full = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) < 7) b = {1'($urandom), 4'd0, 3'($urandom_range(0, 6))};
      else b = 8'($urandom);
      send(b);
      if (b[7]) begin
        tick($urandom_range(0, 4));
        send(8'($urandom));
      end
      tick($urandom_range(0, 3));
    end
    rand_full = 1'b0;
    drain(5000);
    chk(expq.size() == 0, "all_events_seen", 32'(expq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
